// File: rtl/spi_slave_xcvr.sv
// spi_slave_xcvr: SPI mode-0 slave with synchronised pins, tx holding register and rx strobe.
// Bit order is LSB-first unless SPI_SLAVE_MSB_FIRST_EN is defined.
module spi_slave_xcvr #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);
  localparam int CNT_W = $clog2(DATA_W);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_d, cs_d;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic start, leave, bit_in, bit_out, load, last;
  logic [DATA_W-1:0] tx_shift, rx_shift, hold, rx_nx, tx_nx;
  logic hold_full, miso_bit;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  // Deselect outranks any sclk edge seen in the same cycle.
  assign start   = (state == IDLE) && cs_fall;
  assign leave   = (state == ACTIVE) && cs_rise;
  assign bit_in  = (state == ACTIVE) && !cs_rise && sclk_rise;
  assign bit_out = (state == ACTIVE) && !cs_rise && sclk_fall;
  assign load    = start || (bit_out && cnt == '0);
  assign last    = bit_in && cnt == CNT_W'(DATA_W-1);
`ifdef SPI_SLAVE_MSB_FIRST_EN
  assign rx_nx    = {rx_shift[DATA_W-2:0], mosi_s};
  assign tx_nx    = tx_shift << 1;
  assign miso_bit = tx_shift[DATA_W-1];
`else
  assign rx_nx    = {mosi_s, rx_shift[DATA_W-1:1]};
  assign tx_nx    = tx_shift >> 1;
  assign miso_bit = tx_shift[0];
`endif
  always_comb state_nx = start ? ACTIVE : leave ? IDLE : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state    <= state_nx;
      rx_valid <= last;
      if (leave) begin
        cnt      <= '0;
        tx_shift <= '0;
      end else begin
        if (start) cnt <= '0;
        else if (bit_in) cnt <= last ? '0 : cnt + 1'b1;
        if (load) tx_shift <= hold_full ? hold : '0;
        else if (bit_out) tx_shift <= tx_nx;
      end
      if (bit_in) rx_shift <= rx_nx;
      if (last) rx_data <= rx_nx;
      // An accept can only happen while empty, so a same-cycle reload has already taken zeros.
      if (tx_valid && tx_ready) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (load) hold_full <= 1'b0;
    end
  assign tx_ready = ~hold_full;
  assign busy     = (state == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy & miso_bit;
endmodule

// File: tb/tb_spi_slave_xcvr.sv
// tb_spi_slave_xcvr: directed SPI master driving spi_slave_xcvr against a word-level model.
// The model tracks the tx holding word and expected rx words; bit order follows SPI_SLAVE_MSB_FIRST_EN.
module tb_spi_slave_xcvr;
`ifdef SPI_SLAVE_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, tx_ready, rx_valid, busy;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = '0, rx_data;
  int total = 0, pass = 0;
  bit started = 1'b0;
  logic [7:0] mw[0:3];
  logic [7:0] got_miso[0:3];
  logic [7:0] exp_rx[$];
  logic [7:0] m_rx_last = '0, m_hold = '0, e_rx;
  bit m_full = 1'b0;

  spi_slave_xcvr dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every cycle: each rx strobe must deliver the oldest completed word, otherwise rx_data holds.
  always @(negedge clk)
    if (reset && started) begin
      if (rx_valid && exp_rx.size() != 0) begin
        e_rx = exp_rx.pop_front();
        m_rx_last = e_rx;
        check("rx_data", rx_data, e_rx);
      end else begin
        check("rx_valid_idle", rx_valid, 0);
        check("rx_hold", rx_data, m_rx_last);
      end
      check("oe_eq_busy", miso_oe, busy);
    end

  task automatic tx_write(input logic [7:0] d);
    int n = 0;
    tx_data = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 20) begin
      tick(1);
      n++;
    end
    check("tx_ready_wait", n < 20, 1);
    tick(1);
    tx_valid = 1'b0;
    m_hold = d;
    m_full = 1'b1;
  endtask

  // Each word boundary (frame start and after every full word) consumes the holding word or sends zeros.
  task automatic frame(input int nw, input int stop, input bit refill, input logic [7:0] rw);
    logic [7:0] exp_w, got;
    int w, b, idx;
    cs_n = 1'b0;
    exp_w = m_full ? m_hold : 8'h00;
    m_full = 1'b0;
    tick(6);
    check("busy_active", busy, 1);
    got = '0;
    for (int k = 0; k < nw * 8; k++) begin
      if (stop != 0 && k == stop) break;
      w = k / 8;
      b = k % 8;
      idx = MSB ? 7 - b : b;
      mosi = mw[w][idx];
      tick(4);
      sclk = 1'b1;
      got[idx] = miso;
      if (b == 7) exp_rx.push_back(mw[w]);
      tick(4);
      sclk = 1'b0;
      if (refill && k == 2) tx_write(rw);
      if (b == 7) begin
        check("miso_word", got, exp_w);
        got_miso[w] = got;
        exp_w = m_full ? m_hold : 8'h00;
        m_full = 1'b0;
      end
    end
    tick(4);
    cs_n = 1'b1;
    tick(6);
    check("busy_idle", busy, 0);
    check("tx_ready_model", tx_ready, !m_full);
    check("rx_drained", exp_rx.size(), 0);
  endtask

  initial begin
    tick(3);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_miso_oe", miso_oe, 0);
    reset = 1'b1;
    started = 1'b1;
    tick(2);
    check("rst_miso", miso, 0);
    check("rst_rx_data", rx_data, 8'h00);
    // Single word with a queued tx word.
    tx_write(8'h3C);
    check("tx_ready_full", tx_ready, 0);
    mw[0] = 8'hA5;
    frame(1, 0, 1'b0, 8'h00);
    check("lit_rx_a5", rx_data, 8'hA5);
    check("lit_miso_3c", got_miso[0], 8'h3C);
    check("lit_tx_ready", tx_ready, 1);
    // Two back-to-back words, holding refilled during the first.
    tx_write(8'hAA);
    mw[0] = 8'h01;
    mw[1] = 8'hFF;
    frame(2, 0, 1'b1, 8'h55);
    check("lit_miso_aa", got_miso[0], 8'hAA);
    check("lit_miso_55", got_miso[1], 8'h55);
    check("lit_rx_ff", rx_data, 8'hFF);
    // Underrun.
    mw[0] = 8'h5A;
    frame(1, 0, 1'b0, 8'h00);
    check("lit_miso_00", got_miso[0], 8'h00);
    check("lit_rx_5a", rx_data, 8'h5A);
    // Aborted after five bits, then a full frame.
    mw[0] = 8'hC3;
    frame(1, 5, 1'b0, 8'h00);
    check("lit_abort_keep", rx_data, 8'h5A);
    mw[0] = 8'h81;
    frame(1, 0, 1'b0, 8'h00);
    check("lit_rx_81", rx_data, 8'h81);
    // Reset during bit 3 of a frame.
    cs_n = 1'b0;
    tick(6);
    tx_write(8'h99);
    check("mid_tx_ready", tx_ready, 0);
    for (int b = 0; b < 3; b++) begin
      mosi = 1'b1;
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    sclk = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_miso_oe", miso_oe, 0);
    check("arst_miso", miso, 0);
    check("arst_tx_ready", tx_ready, 1);
    check("arst_rx_valid", rx_valid, 0);
    check("arst_rx_data", rx_data, 8'h00);
    exp_rx.delete();
    m_rx_last = '0;
    m_full = 1'b0;
    @(negedge clk);
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
    mw[0] = 8'h7E;
    frame(1, 0, 1'b0, 8'h00);
    check("lit_rx_7e", rx_data, 8'h7E);
    check("lit_miso_rst", got_miso[0], 8'h00);
    tick(4);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/spi_slave_xcvr.md
Name: spi_slave_xcvr

Overview:
- SPI mode-0 slave transceiver.
- Sits at the far end of the link driven by the team's 8-bit SPI shift register: it receives MOSI words from the master and returns MISO words.
- All SPI pins are treated as asynchronous; they are synchronised into clk and edge-detected there.
- Presents parallel tx/rx interfaces to local logic with a valid/ready handshake on tx and a one-cycle strobe on rx.
- Default bit order is LSB-first, matching the master-side shifter, which shifts right with serial in at the MSB.

Parameters:
- DATA_W, 8, word length in bits (≥2).
- SYNC_STAGES, 2, flip-flop depth of the sclk/cs_n/mosi synchronisers (≥2).

Ports:
- clk  input  1  system clock; frequency ≥ 4× SCLK.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock from master; idles low (CPOL=0).
- cs_n  input  1  chip select, active low.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- miso_oe  output  1  MISO output enable; high while selected.
- tx_data  input  DATA_W  next word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty; a word is accepted when tx_valid&&tx_ready.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle strobe; rx_data updated this cycle.
- busy  output  1  high while a frame is active (synchronised cs_n low).

Behaviour:
- Reset (async assert, sync release) clears the following:
  - synchronisers to sclk=0, cs_n=1, mosi=0;
  - state IDLE, bit count 0;
  - tx/rx shift registers, holding register and rx_data to 0;
  - outputs: miso=0, miso_oe=0, rx_valid=0, busy=0, tx_ready=1.
- Synchronisers:
  - Each SPI input passes through SYNC_STAGES flops.
  - One further flop on sclk and cs_n supplies the previous value for edge detection.
  - All edges below refer to these synchronised signals.
- Holding register:
  - On tx_valid&&tx_ready, capture tx_data and set tx_ready=0 the next cycle.
  - tx_ready returns to 1 the cycle after the shift register loads from it.
- State IDLE, cs_n high:
  - busy=0, miso_oe=0.
  - Edges on sclk are ignored.
- IDLE → ACTIVE on cs_n falling edge:
  - Load the tx shift register from the holding register if it is full (holding then becomes empty).
  - Otherwise load all zeros (underrun).
  - Bit count = 0; busy=1 and miso_oe=1 from the next cycle.
- In ACTIVE, on sclk rising edge:
  - rx_shift <= {mosi, rx_shift[DATA_W-1:1]}; bit count +1.
  - If the count was DATA_W-1:
    - rx_data <= the assembled word, including this bit;
    - rx_valid=1 for exactly one cycle;
    - count wraps to 0.
- In ACTIVE, on sclk falling edge:
  - If count≠0, tx_shift <= tx_shift >> 1.
  - If count==0 (word boundary), reload tx_shift from holding or zeros, with the same rule as at frame start.
- miso = tx_shift[0] in ACTIVE; 0 in IDLE.
- Back-to-back words within one frame are supported without gaps.
- ACTIVE → IDLE on cs_n rising edge, including mid-word:
  - A partial word is discarded: no rx_valid, rx_data unchanged.
  - Count resets to 0; tx_shift cleared.
  - The holding register is kept.
- Simultaneous events:
  - cs_n rise together with an sclk rise: cs_n wins and the bit is dropped.
  - tx accept in the same cycle as a reload: the reload takes the old contents (or zeros if empty); the new word goes into holding.
- rx_valid is not gated by any ready; local logic must consume it in the strobe cycle.
- Latency: rx_valid asserts SYNC_STAGES+1 clk cycles after the final sclk rising edge at the pin.
- Reset mid-frame: immediate return to the reset values; the frame is lost.

Optional Feature:
- Macro: SPI_SLAVE_MSB_FIRST_EN.
- Defined:
  - rx shifts as {rx_shift[DATA_W-2:0], mosi};
  - tx shifts left with miso = tx_shift[DATA_W-1];
  - all other timing is identical.
- Undefined: LSB-first as described above.

Test Plan:
- Reset, then drive one frame with mosi word 0xA5, LSB-first, after tx_data=0x3C was accepted → rx_valid pulses once with rx_data=0xA5; master samples 0x3C on miso; tx_ready returns 1 after the load.
- One frame carrying two words (0x01, 0xFF) with holding refilled to 0x55 after the first load, tx first word 0xAA → two rx_valid pulses with 0x01 then 0xFF; miso returns 0xAA then 0x55.
- Frame with no tx word written → miso carries 0x00; rx still works.
- cs_n raised after 5 bits of 0xC3 → no rx_valid; rx_data keeps its previous value; next full frame of 0x81 → rx_data=0x81.
- reset asserted at bit 3 of a frame → all outputs at reset values within the same cycle; the following frame of 0x7E is received correctly.
- With SPI_SLAVE_MSB_FIRST_EN defined, mosi bit sequence 1,0,1,0,0,1,0,1 (first to last) → rx_data=0xA5; tx 0x3C appears on miso as 0,0,1,1,1,1,0,0.
